branch_trace_driver: RTL and testbench

- Drives the predictor-side branch interface from a preloaded branch trace:
  - presents one branch IP per cycle plus the resolved outcome of the previous branch;
  - samples the returned prediction and scores it against the true outcome.
- Sits opposite the branch predictor in the predictor evaluation harness: it produces `ip`/`taken` and consumes `prediction`.
- Reports branch and misprediction counts for accuracy measurement.

---
 rtl/branch_trace_driver.sv | 153 +++++++++++++++
 tb/tb_branch_trace_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_trace_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_trace_driver : replays a preloaded branch trace into a predictor and
//                       scores the returned predictions.   rev 1.0
// ----------------------------------------------------------------------------
module branch_trace_driver #(
   parameter int IP_W   = 64,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [IP_W-1:0]   load_ip,
   input  logic              load_taken,
   input  logic              start,
   input  logic [ADDR_W:0]   trace_len,
   output logic [IP_W-1:0]   output_ip,
   output logic              output_taken,
   input  logic              input_prediction,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] IDX_ONE = 1;
   localparam logic [ADDR_W:0]   LEN_ONE = 1;
   localparam logic [CNT_W-1:0]  CNT_ONE = 1;

   // Entry layout: {taken, ip}
   logic [IP_W:0] trace_mem [2**ADDR_W];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [IP_W:0]     rd_q, rd_d;
   logic              otaken_q, otaken_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  bc_q, bc_d;
   logic [CNT_W-1:0]  mc_q, mc_d;
   logic              mem_we;
   logic              score;
   logic              last_entry;
   logic [ADDR_W-1:0] idx_next;

   assign last_entry = ({1'b0, idx_q} == (len_q - LEN_ONE));
   assign idx_next   = idx_q + IDX_ONE;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      rd_d     = rd_q;
      otaken_d = otaken_q;
      bc_d     = bc_q;
      mc_d     = mc_q;
      mem_we   = 1'b0;
      score    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            mem_we = load_we;
            if (start) begin
               bc_d  = '0;
               mc_d  = '0;
               len_d = trace_len;
               if (trace_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  // Entry 0 is fetched now so RUN cycle 0 already shows ip[0]
                  state_d  = S_RUN;
                  idx_d    = '0;
                  rd_d     = trace_mem[0];
                  otaken_d = 1'b0;
               end
            end
         end
         S_RUN: begin
            score    = (idx_q != '0);
            otaken_d = rd_q[IP_W];
            if (last_entry) begin
               state_d = S_FLUSH;
            end else begin
               idx_d = idx_next;
               rd_d  = trace_mem[idx_next];
            end
         end
         S_FLUSH: begin
            score    = 1'b1;
            state_d  = S_DONE;
            rd_d     = '0;
            otaken_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      // output_taken currently holds the outcome the arriving prediction refers to
      if (score) begin
         if (bc_q != {CNT_W{1'b1}}) bc_d = bc_q + CNT_ONE;
         if ((input_prediction != otaken_q) && (mc_q != {CNT_W{1'b1}})) mc_d = mc_q + CNT_ONE;
      end

      busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (mem_we) trace_mem[load_addr] <= {load_taken, load_ip};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         rd_q     <= '0;
         otaken_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bc_q     <= '0;
         mc_q     <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         rd_q     <= rd_d;
         otaken_q <= otaken_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         bc_q     <= bc_d;
         mc_q     <= mc_d;
      end
   end

   assign output_ip        = rd_q[IP_W-1:0];
   assign output_taken     = otaken_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign branch_count     = bc_q;
   assign mispredict_count = mc_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_trace_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_trace_driver : directed bench for branch_trace_driver.   rev 1.0
// ----------------------------------------------------------------------------
module tb_branch_trace_driver;

   localparam int IP_W   = 64;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              load_we = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [IP_W-1:0]   load_ip = '0;
   logic              load_taken = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   trace_len = '0;
   logic [IP_W-1:0]   output_ip;
   logic              output_taken;
   logic              pred = 1'b0;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  branch_count;
   logic [CNT_W-1:0]  mispredict_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] ips [3] = '{64'h100, 64'h200, 64'h300};
   logic        tks [3] = '{1'b1, 1'b0, 1'b1};

   branch_trace_driver #(.IP_W(IP_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .load_we          (load_we),
      .load_addr        (load_addr),
      .load_ip          (load_ip),
      .load_taken       (load_taken),
      .start            (start),
      .trace_len        (trace_len),
      .output_ip        (output_ip),
      .output_taken     (output_taken),
      .input_prediction (pred),
      .busy             (busy),
      .done             (done),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int addr, input logic [63:0] ip, input logic t);
      load_we    = 1'b1;
      load_addr  = addr[ADDR_W-1:0];
      load_ip    = ip;
      load_taken = t;
      tick();
      load_we    = 1'b0;
   endtask

   // Replays the 3-entry trace with prediction fixed at 1; optionally pokes
   // start/load_we during RUN cycle 0, which must have no effect.
   task automatic run3(input string tag, input bit perturb);
      pred      = 1'b1;
      trace_len = 11'd3;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_ip"}, output_ip, (k < 3) ? ips[k] : ips[2]);
         chk({tag, "_taken"}, {63'd0, output_taken}, (k == 0) ? 64'd0 : {63'd0, tks[k-1]});
         chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
         chk({tag, "_done_lo"}, {63'd0, done}, 64'd0);
         if (perturb && k == 0) begin
            start      = 1'b1;
            trace_len  = 11'd1;
            load_we    = 1'b1;
            load_addr  = 10'd1;
            load_ip    = 64'hBAD;
            load_taken = 1'b1;
         end
         tick();
         start   = 1'b0;
         load_we = 1'b0;
      end
      chk({tag, "_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
      chk({tag, "_ip_idle"}, output_ip, 64'd0);
      chk({tag, "_bc"}, {32'd0, branch_count}, 64'd3);
      chk({tag, "_mc"}, {32'd0, mispredict_count}, 64'd1);
   endtask

   initial begin
      int cyc;

      // Reset then idle
      tick();
      reset = 1'b0;
      repeat (5) tick();
      chk("rst_ip", output_ip, 64'd0);
      chk("rst_taken", {63'd0, output_taken}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_bc", {32'd0, branch_count}, 64'd0);
      chk("rst_mc", {32'd0, mispredict_count}, 64'd0);

      // Basic 3-entry run
      for (int i = 0; i < 3; i++) load(i, ips[i], tks[i]);
      run3("run_a", 1'b0);

      // Zero-length run from DONE
      trace_len = 11'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_done", {63'd0, done}, 64'd1);
      chk("zero_busy", {63'd0, busy}, 64'd0);
      chk("zero_bc", {32'd0, branch_count}, 64'd0);
      chk("zero_mc", {32'd0, mispredict_count}, 64'd0);

      // Full-depth run, all taken, prediction tied to 0
      for (int i = 0; i < 1024; i++) load(i, 64'h1000 + 64'(i), 1'b1);
      pred      = 1'b0;
      trace_len = 11'd1024;
      start     = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      chk("full_busy", {63'd0, busy}, 64'd1);
      chk("full_ip0", output_ip, 64'h1000);
      while (!done && cyc < 2000) begin
         tick();
         cyc++;
      end
      chk("full_cycles", 64'(cyc), 64'd1026);
      chk("full_bc", {32'd0, branch_count}, 64'd1024);
      chk("full_mc", {32'd0, mispredict_count}, 64'd1024);

      // Reset during the second RUN cycle, then restart
      for (int i = 0; i < 3; i++) load(i, ips[i], tks[i]);
      pred      = 1'b1;
      trace_len = 11'd3;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("mid_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_done", {63'd0, done}, 64'd0);
      chk("mid_rst_bc", {32'd0, branch_count}, 64'd0);
      chk("mid_rst_ip", output_ip, 64'd0);
      run3("run_b", 1'b0);

      // start/load_we during RUN must be ignored, now and on the next replay
      run3("run_c", 1'b1);
      run3("run_d", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
